muldiv_iter: RTL and testbench
==============================

MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal: even, >= 4).
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk     input   1      single clock, all state changes on rising edge
  rst     input   1      asynchronous, active-low reset
  start   input   1      request new operation, sampled in IDLE only
  divSel  input   1      0 = multiply, 1 = divide
  isSigned input  1      1 = two's-complement operands, 0 = unsigned
  a       input   WIDTH  operand A / dividend / HI-LO write data
  b       input   WIDTH  operand B / divisor
  hiWe    input   1      write a into hi (IDLE only)
  loWe    input   1      write a into lo (IDLE only)
  cancel  input   1      abort operation in progress
  hi      output  WIDTH  product upper half / remainder
  lo      output  WIDTH  product lower half / quotient
  busy    output  1      operation in progress
  done    output  1      one-cycle completion pulse
  dz      output  1      last completed divide had zero divisor
REQ-003 SHALL use one clock and an asynchronous, active-low reset on rst; no other clock or reset.

Function
REQ-004 SHALL implement FSM states IDLE, CALC, FIX; busy = (state != IDLE), combinationally from the state register.
REQ-005 IDLE with start=1 and cancel=0 SHALL latch a, b, divSel, isSigned and enter CALC on that edge; operands may change afterwards without effect.
REQ-006 CALC SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes, for exactly WIDTH cycles, then enter FIX.
REQ-007 FIX SHALL apply signs, write hi/lo, return to IDLE and, on the same edge, set done=1 for exactly one cycle.
REQ-008 Latency SHALL be WIDTH+1 cycles: busy high for WIDTH+1 cycles after the start edge; hi/lo valid in the cycle done=1.
REQ-009 Multiply SHALL produce the full 2*WIDTH product, hi = upper WIDTH bits, lo = lower WIDTH bits; signed uses sign(a) XOR sign(b).
REQ-010 Divide SHALL give lo = quotient truncated toward zero and hi = remainder; signed remainder takes the sign of a.
REQ-011 Signed MIN / -1 SHALL yield lo = MIN (wrapped) and hi = 0; no flag.
REQ-012 Divide with b = 0 SHALL yield lo = all ones and hi = a, regardless of isSigned, and set dz=1; any other completed operation SHALL clear dz.
REQ-013 hiWe/loWe SHALL write a into hi/lo on the edge only in IDLE with start=0; both may be set together; ignored while busy.
REQ-014 start with hiWe/loWe in the same IDLE cycle: start SHALL win, writes discarded.
REQ-015 start while busy SHALL be ignored (no queueing).
REQ-016 cancel=1 in CALC or FIX SHALL return to IDLE next edge, leave hi, lo, dz unchanged and suppress done; cancel in IDLE SHALL block start and hiWe/loWe that cycle.
REQ-017 Internal iteration counter SHALL be sized ceil(log2(WIDTH+1)) bits and reset to 0 on every start.

Reset
REQ-018 rst=0 SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0, dz=0, counter=0, regardless of clk.
REQ-019 Reset asserted mid-operation SHALL discard the operation; no done after release.
REQ-020 First start SHALL be accepted on the first rising edge with rst=1.

Verification (WIDTH=32)
REQ-021 Signed mul a=0xFFFFFFFD, b=5 -> busy 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1, dz=0.
REQ-022 Unsigned div a=100, b=7 -> lo=14, hi=2; signed div a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-023 Div a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, dz=1; next mul 2*3 -> lo=6, hi=0, dz=0.
REQ-024 Signed div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-025 hi=0xAA, lo=0xBB, start mul, cancel at cycle 10 -> busy drops next edge, no done, hi=0xAA, lo=0xBB; start held while busy -> ignored.
REQ-026 rst=0 at CALC cycle 5 -> all outputs 0 immediately; hiWe+loWe with a=0x55 in IDLE -> hi=lo=0x55; hiWe with start -> hi unchanged.

Source files
------------

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiplier / divider with HI/LO result registers.
//
// A multiply or divide is launched from IDLE with start. The magnitudes of the
// operands are processed one bit per cycle for WIDTH cycles (shift-add multiply
// or restoring divide). A final FIX cycle applies signs, writes hi/lo and pulses
// done. hi/lo can also be loaded directly from a while idle.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           launch an operation (IDLE only)
//   divSel          0 = multiply, 1 = divide
//   isSigned        operands are two's complement
//   a, b            operands; a is also the hi/lo write data
//   hiWe, loWe      write a into hi / lo (IDLE, no start, no cancel)
//   cancel          abort the operation in progress; blocks requests in IDLE
//   hi, lo          product high/low half, or remainder/quotient
//   busy            operation in progress
//   done            one-cycle completion pulse
//   dz              last completed divide had a zero divisor
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             divSel,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;   // sign of product / quotient
    logic             neg_rem_q, neg_rem_d;   // sign of remainder (follows a)
    logic [WIDTH-1:0] a_raw_q, a_raw_d;       // original dividend, returned on divide-by-zero
    logic [WIDTH-1:0] opb_q, opb_d;           // |b|: multiplicand or divisor
    logic [WIDTH-1:0] acc_q, acc_d;           // product high half / partial remainder
    logic [WIDTH-1:0] sh_q, sh_d;             // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    // Operand magnitudes at launch time.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = isSigned & a[WIDTH-1];
        b_neg = isSigned & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration step of each algorithm.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier bit is set,
        // then shift {acc, sh} right by one; the carry lands in acc's MSB.
        mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        // Restoring: shift next dividend bit into the remainder and try to
        // subtract; no borrow means the quotient bit is 1.
        rem_sh  = {acc_q, sh_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, opb_q};
    end

    // Sign fix-up of the finished magnitudes.
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               div_zero;

    always_comb begin
        prod_mag = {acc_q, sh_q};
        prod_fix = neg_res_q ? (~prod_mag + 1'b1) : prod_mag;
        quo_fix  = neg_res_q ? (~sh_q + 1'b1) : sh_q;
        rem_fix  = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
        div_zero = (opb_q == '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_raw_d   = a_raw_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!cancel) begin
                    if (start) begin
                        // start takes priority over direct hi/lo writes
                        state_d   = S_CALC;
                        cnt_d     = '0;
                        div_d     = divSel;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        a_raw_d   = a;
                        opb_d     = b_mag;
                        acc_d     = '0;
                        sh_d      = a_mag;
                    end else begin
                        if (hiWe) hi_d = a;
                        if (loWe) lo_d = a;
                    end
                end
            end

            S_CALC: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (div_q) begin
                        if (!trial[WIDTH]) begin
                            acc_d = trial[WIDTH-1:0];
                            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = rem_sh[WIDTH-1:0];
                            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                        dz_d = 1'b0;
                    end else if (div_zero) begin
                        // Divide by zero: fixed result independent of signedness.
                        hi_d = a_raw_q;
                        lo_d = '1;
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                        dz_d = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_raw_q   <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_raw_q   <= a_raw_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Testbench for muldiv_iter (WIDTH=32): directed cases plus randomized
// operations against an arithmetic reference model.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, divSel = 1'b0, isSigned = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        hiWe = 1'b0, loWe = 1'b0, cancel = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, dz;

    int tests = 0;
    int fails = 0;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .divSel(divSel), .isSigned(isSigned),
        .a(a), .b(b), .hiWe(hiWe), .loWe(loWe), .cancel(cancel),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit values.
    function automatic void model(input logic [31:0] ta, input logic [31:0] tbv,
                                  input logic d, input logic s,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic edz);
        logic [63:0] p, qv, rv;
        longint      sq, sr;
        edz = 1'b0;
        if (!d) begin
            if (s) p = longint'($signed(ta)) * longint'($signed(tbv));
            else   p = {32'b0, ta} * {32'b0, tbv};
            eh = p[63:32];
            el = p[31:0];
        end else if (tbv == 32'd0) begin
            eh  = ta;
            el  = 32'hFFFF_FFFF;
            edz = 1'b1;
        end else if (s) begin
            sq = longint'($signed(ta)) / longint'($signed(tbv));
            sr = longint'($signed(ta)) % longint'($signed(tbv));
            qv = sq;
            rv = sr;
            el = qv[31:0];
            eh = rv[31:0];
        end else begin
            el = ta / tbv;
            eh = ta % tbv;
        end
    endfunction

    // Launch one operation, scramble inputs while busy, measure busy length,
    // then check results and the single-cycle done pulse.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv,
                         input logic d, input logic s, input bit hold, input bit wait_edge);
        logic [31:0] eh, el;
        logic        edz;
        int          n;
        bit          got;
        model(ta, tbv, d, s, eh, el, edz);
        if (wait_edge) @(negedge clk);
        a = ta; b = tbv; divSel = d; isSigned = s; start = 1'b1;
        n = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
            if (busy) n++;
            if (!hold || i >= 20) start = 1'b0;
            a = $urandom; b = $urandom; divSel = 1'($urandom); isSigned = 1'($urandom);
        end
        start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        chk("busy_cycles", 64'(n), 64'd33);
        chk("hi", 64'(hi), 64'(eh));
        chk("lo", 64'(lo), 64'(el));
        chk("dz", 64'(dz), 64'(edz));
        @(negedge clk);
        chk("done_pulse_end", 64'({done, busy}), 64'd0);
    endtask

    task automatic wr(input logic hw, input logic lw, input logic [31:0] val);
        @(negedge clk);
        hiWe = hw; loWe = lw; a = val;
        @(negedge clk);
        hiWe = 1'b0; loWe = 1'b0;
    endtask

    initial begin
        int          cnt;
        logic [31:0] ra, rb;
        int          sel;

        // Reset state
        #3;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_flags", 64'({busy, done, dz}), 64'd0);

        // First start accepted on first rising edge after release.
        @(negedge clk);
        rst = 1'b1;
        do_op(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0);

        do_op(32'd100, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        do_op(32'h1234, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        do_op(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op(32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized operations.
        for (int k = 0; k < 16; k++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) rb = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 15))
                                                                : 32'($urandom_range(1, 15));
            else               rb = $urandom;
            do_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end

        // Cancel mid-operation with start held high while busy.
        wr(1'b1, 1'b0, 32'hAA);
        wr(1'b0, 1'b1, 32'hBB);
        chk("wr_hi", 64'(hi), 64'hAA);
        chk("wr_lo", 64'(lo), 64'hBB);
        @(negedge clk);
        a = 32'd5; b = 32'd7; divSel = 1'b0; isSigned = 1'b0; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = $urandom;
            if (i == 9) begin start = 1'b0; cancel = 1'b1; end
        end
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy_done", 64'({busy, done}), 64'd0);
        chk("cancel_hi", 64'(hi), 64'hAA);
        chk("cancel_lo", 64'(lo), 64'hBB);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("cancel_quiet", 64'(cnt), 64'd0);

        // cancel in IDLE blocks start and writes.
        @(negedge clk);
        cancel = 1'b1; start = 1'b1; hiWe = 1'b1; loWe = 1'b1; a = 32'h99;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
        chk("idle_cancel_busy", 64'(busy), 64'd0);
        chk("idle_cancel_hilo", 64'({hi, lo}), {32'hAA, 32'hBB});

        // Reset during CALC.
        do_op(32'd100, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a = 32'd9; b = 32'd9; divSel = 1'b0; isSigned = 1'b0; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_hilo", 64'({hi, lo}), 64'd0);
        chk("mid_rst_flags", 64'({busy, done, dz}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("post_rst_quiet", 64'(cnt), 64'd0);

        // Simultaneous hi/lo write, then write colliding with start.
        wr(1'b1, 1'b1, 32'h55);
        chk("wr_both", 64'({hi, lo}), {32'h55, 32'h55});
        @(negedge clk);
        a = 32'h77; b = 32'd3; divSel = 1'b0; isSigned = 1'b0; start = 1'b1; hiWe = 1'b1;
        @(negedge clk);
        start = 1'b0; hiWe = 1'b0;
        chk("start_wins_hi", 64'(hi), 64'h55);
        chk("start_wins_busy", 64'(busy), 64'd1);
        cnt = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            cnt++;
        end
        chk("start_wins_done", 64'(done), 64'd1);
        chk("start_wins_res", 64'({hi, lo}), {32'h0, 32'h165});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
